// File: rtl/axi_slave_rd_burst.sv
// AXI4 read-burst slave: one outstanding burst, 2-entry return FIFO, one-cycle-latency memory port.
// Optional WRAP addressing is compiled in with `define AXI_SLV_RD_WRAP_EN.
// state | meaning
// IDLE  | arready high, waiting for an AR handshake
// READ  | issuing memory reads and returning beats until the rlast handshake
module axi_slave_rd_burst #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 30,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rd_done
);

    localparam logic [2:0] SIZE_MAX    = 3'($clog2(DATA_W / 8));
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, READ} state_t;
    typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_t;

    state_t            state_q;
    mode_t             mode_q;
    logic              arready_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] incr_q;
    logic [ADDR_W-1:0] wrap_mask_q;
    logic              err_q;
    logic [8:0]        issue_left_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic              fifo_last_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              rd_done_q;

    logic              ar_hs;
    logic              pop;
    logic              head_last;
    logic [2:0]        occ;
    logic              size_err;
    logic              wrap_ok;
    logic              ar_err;
    mode_t             ar_mode;
    logic [ADDR_W-1:0] ar_incr;
    logic [ADDR_W-1:0] ar_mask;

    assign ar_hs     = s_axi_arvalid & arready_q;
    assign s_axi_rvalid = (count_q != 2'd0);
    assign pop       = s_axi_rvalid & s_axi_rready;
    assign head_last = fifo_last_q[rd_ptr_q];

    // Occupancy counts the beat in flight from memory so the FIFO can never overflow.
    assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign mem_rd_en = (state_q == READ) && (issue_left_q != 9'd0) && (occ < 3'd2);

    assign size_err = (s_axi_arsize > SIZE_MAX);
`ifdef AXI_SLV_RD_WRAP_EN
    logic len_pow2;
    assign len_pow2 = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                      (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
    assign wrap_ok  = (s_axi_arburst == BURST_WRAP) && len_pow2;
`else
    assign wrap_ok  = 1'b0;
`endif
    assign ar_err  = size_err || (s_axi_arburst == BURST_RSVD) ||
                     ((s_axi_arburst == BURST_WRAP) && !wrap_ok);
    assign ar_mode = (s_axi_arburst == BURST_FIXED) ? MODE_FIXED :
                     wrap_ok                        ? MODE_WRAP  : MODE_INCR;
    assign ar_incr = {{(ADDR_W-1){1'b0}}, 1'b1} << s_axi_arsize;
    assign ar_mask = ((ADDR_W'(s_axi_arlen) + {{(ADDR_W-1){1'b0}}, 1'b1}) << s_axi_arsize)
                     - {{(ADDR_W-1){1'b0}}, 1'b1};

    always_comb begin
        addr_d = addr_q;
        case (mode_q)
            MODE_INCR: addr_d = addr_q + incr_q;
            MODE_WRAP: addr_d = (addr_q & ~wrap_mask_q) | ((addr_q + incr_q) & wrap_mask_q);
            default:   addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            mode_q          <= MODE_FIXED;
            arready_q       <= 1'b1;
            id_q            <= '0;
            addr_q          <= '0;
            incr_q          <= '0;
            wrap_mask_q     <= '0;
            err_q           <= 1'b0;
            issue_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
            rd_done_q       <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        state_q      <= READ;
                        arready_q    <= 1'b0;
                        id_q         <= s_axi_arid;
                        addr_q       <= s_axi_araddr;
                        incr_q       <= ar_incr;
                        wrap_mask_q  <= ar_mask;
                        mode_q       <= ar_mode;
                        err_q        <= ar_err;
                        issue_left_q <= {1'b0, s_axi_arlen} + 9'd1;
                    end
                end
                READ: begin
                    if (pop && head_last) begin
                        state_q   <= IDLE;
                        arready_q <= 1'b1;
                        rd_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (mem_rd_en) begin
                addr_q       <= addr_d;
                issue_left_q <= issue_left_q - 9'd1;
            end
            inflight_q      <= mem_rd_en;
            inflight_last_q <= mem_rd_en && (issue_left_q == 9'd1);

            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= mem_rd_data;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = fifo_data_q[rd_ptr_q];
    assign s_axi_rlast   = s_axi_rvalid & head_last;
    assign s_axi_rresp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign mem_rd_addr   = addr_q;
    assign rd_done       = rd_done_q;

endmodule

// File: tb/tb_axi_slave_rd_burst.sv
// Randomized bench for axi_slave_rd_burst against a burst-level address/response model.
`timescale 1ns/1ps
module tb_axi_slave_rd_burst;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 30;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ID_W-1:0]   s_axi_arid;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              rd_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_slave_rd_burst #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .rd_done(rd_done)
    );

    function automatic logic [63:0] pat(input logic [29:0] a);
        return {2'b01, a, 2'b10, a ^ 30'h2AAA_AAAA};
    endfunction

    // Memory answers one cycle after the strobe; any other cycle it drives noise.
    logic        pend_en = 1'b0;
    logic [29:0] pend_addr = '0;
    always @(negedge clk) begin
        pend_en   = mem_rd_en;
        pend_addr = mem_rd_addr;
    end
    always @(posedge clk) begin
        #1;
        mem_rd_data = pend_en ? pat(pend_addr) : {$urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_arready"}, 64'(s_axi_arready), 64'd1);
        chk({tag, "_rvalid"},  64'(s_axi_rvalid),  64'd0);
        chk({tag, "_rlast"},   64'(s_axi_rlast),   64'd0);
        chk({tag, "_rresp"},   64'(s_axi_rresp),   64'd0);
        chk({tag, "_rid"},     64'(s_axi_rid),     64'd0);
        chk({tag, "_rdata"},   64'(s_axi_rdata),   64'd0);
        chk({tag, "_rd_en"},   64'(mem_rd_en),     64'd0);
        chk({tag, "_rd_addr"}, 64'(mem_rd_addr),   64'd0);
        chk({tag, "_rd_done"}, 64'(rd_done),       64'd0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk_reset("abort_in");
        @(negedge clk);
        chk_reset("abort_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_rvalid",  64'(s_axi_rvalid),  64'd0);
            chk("abort_rd_done", 64'(rd_done),       64'd0);
            chk("abort_rd_en",   64'(mem_rd_en),     64'd0);
            chk("abort_arready", 64'(s_axi_arready), 64'd1);
        end
    endtask

    function automatic logic next_rready(input int rmode, input int cyc);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return (cyc % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // rmode: 0 rready held high, 1 toggling, 2 random; abort_at >= 0 resets during that beat.
    task automatic run_burst(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int rmode, input int abort_at);
        logic [29:0] exp_addr [256];
        logic [1:0]  exp_resp;
        logic        wrap_ok;
        longint      nb, total, base;
        int cyc = 0, k = 0, issued = 0, max_out = 0, first = -1, last = -1, outst;
        bit done = 0, aborted = 0, arrdy = 0;

`ifdef AXI_SLV_RD_WRAP_EN
        wrap_ok = (burst == 2'b10) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
`else
        wrap_ok = 1'b0;
`endif
        exp_resp = (size > 3'd3 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) ? 2'b10 : 2'b00;
        nb    = longint'(1) << size;
        total = (longint'(len) + 1) * nb;
        base  = (longint'(addr) / total) * total;
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'b00)
                exp_addr[i] = addr;
            else if (wrap_ok)
                exp_addr[i] = 30'(base + ((longint'(addr) - base) + longint'(i) * nb) % total);
            else
                exp_addr[i] = 30'(longint'(addr) + longint'(i) * nb);
        end

        for (int i = 0; i < 50 && !arrdy; i++) begin
            @(negedge clk);
            arrdy = s_axi_arready;
        end
        chk("ar_wait", 64'(arrdy), 64'd1);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = next_rready(rmode, 0);

        while (!done && !aborted && cyc < 3000) begin
            @(negedge clk);
            if (cyc == 0) chk("arready_low", 64'(s_axi_arready), 64'd0);
            if (mem_rd_en) begin
                if (issued <= int'(len)) chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr[issued]));
                issued++;
            end
            if (abort_at >= 0 && k == abort_at && s_axi_rvalid) begin
                reset_pulse();
                aborted = 1;
            end else begin
                outst = issued - k - ((s_axi_rvalid && s_axi_rready) ? 1 : 0);
                if (outst > max_out) max_out = outst;
                if (s_axi_rvalid) begin
                    if (first < 0) first = cyc;
                    chk("rdata", 64'(s_axi_rdata), pat(exp_addr[k]));
                    chk("rid",   64'(s_axi_rid),   64'(id));
                    chk("rresp", 64'(s_axi_rresp), 64'(exp_resp));
                    chk("rlast", 64'(s_axi_rlast), 64'(k == int'(len)));
                    if (s_axi_rready) begin
                        k++;
                        if (k == int'(len) + 1) begin
                            done = 1;
                            last = cyc;
                        end
                    end
                end
                @(posedge clk);
                #1;
                cyc++;
                s_axi_rready = next_rready(rmode, cyc);
            end
        end
        if (aborted) return;

        chk("burst_done", 64'(done), 64'd1);
        chk("beats", 64'(k), 64'(int'(len) + 1));
        chk("max_outst_ok", 64'(max_out <= 2), 64'd1);
        if (rmode == 0) begin
            chk("first_lat", 64'(first), 64'd2);
            chk("no_bubble", 64'(last - first), 64'(len));
        end
        @(negedge clk);
        chk("rd_done_hi",   64'(rd_done),       64'd1);
        chk("arready_back", 64'(s_axi_arready), 64'd1);
        chk("rvalid_end",   64'(s_axi_rvalid),  64'd0);
        chk("no_extra_rd",  64'(mem_rd_en),     64'd0);
        chk("issued", 64'(issued), 64'(int'(len) + 1));
        @(negedge clk);
        chk("rd_done_lo", 64'(rd_done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sz;
        logic [7:0] ln;
        rst_n = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst_post");

        run_burst(4'h1, 30'h100, 8'd3, 3'd3, 2'b01, 0, -1);
        run_burst(4'h2, 30'h040, 8'd2, 3'd3, 2'b00, 0, -1);
        run_burst(4'h3, 30'h200, 8'd7, 3'd3, 2'b01, 1, -1);
        run_burst(4'h4, 30'h018, 8'd3, 3'd3, 2'b10, 0, -1);
        run_burst(4'hA, 30'h080, 8'd1, 3'd4, 2'b01, 0, -1);
        run_burst(4'h6, 30'h300, 8'd7, 3'd3, 2'b01, 0, 2);
        run_burst(4'h5, 30'h500, 8'd3, 3'd3, 2'b01, 0, -1);
        run_burst(4'h7, 30'h3FFF_FFF0, 8'd3, 3'd3, 2'b01, 2, -1);
        run_burst(4'h9, 30'h034, 8'd4, 3'd2, 2'b10, 0, -1);
        run_burst(4'hB, 30'h0F0, 8'd2, 3'd1, 2'b11, 1, -1);
        run_burst(4'h8, 30'h1000, 8'd255, 3'd2, 2'b01, 2, -1);

        for (int n = 0; n < 40; n++) begin
            sz = 3'($urandom_range(0, 4));
            ln = ($urandom_range(0, 1) == 1) ? 8'((2 << $urandom_range(0, 3)) - 1)
                                             : 8'($urandom_range(0, 20));
            run_burst(4'($urandom_range(0, 15)),
                      30'($urandom) & ~30'((1 << sz) - 1),
                      ln, sz, 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
